// File: rtl/m_conv_mac_3_pkg.sv
// Shared fixed-point constants for the layer-3 convolution MAC and its
// rescale/saturate stage.
package m_conv_mac_3_pkg;

   localparam int DATA_W  = 16;
   localparam int FRAC    = 8;
   localparam int TAP_W   = 4;
   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

endpackage

// File: rtl/m_conv_sat_relu.sv
// Combinational output stage: adds the Q8.8 bias, rescales the accumulator
// back to Q8.8, saturates to 16 bits and optionally applies ReLU.
module m_conv_sat_relu
   import m_conv_mac_3_pkg::*;
#(
   parameter int ACC_W = 36,
   parameter int FRAC  = m_conv_mac_3_pkg::FRAC,
   parameter bit RELU  = 1'b1
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] bias,
   output logic signed [DATA_W-1:0] result
);

   localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(SAT_MAX);
   localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(SAT_MIN);

   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;

   // One extra bit of headroom so the bias add can never wrap.
   always_comb begin
      sum     = {acc[ACC_W-1], acc} + ((ACC_W+1)'(bias) <<< FRAC);
      shifted = sum >>> FRAC;
      if (shifted > HI) begin
         result = DATA_W'(SAT_MAX);
      end else if (shifted < LO) begin
         result = DATA_W'(SAT_MIN);
      end else begin
         result = shifted[DATA_W-1:0];
      end
      if (RELU && result[DATA_W-1]) begin
         result = '0;
      end
   end

endmodule

// File: rtl/m_conv_mac_3.sv
// Layer-3 convolution MAC: multiplies each K*K window against a weight register
// file, accumulates, then rescales/saturates one Q8.8 result per window.
module m_conv_mac_3
   import m_conv_mac_3_pkg::*;
#(
   parameter int K       = 3,
   parameter int NUM_OUT = 36,
   parameter int FRAC    = m_conv_mac_3_pkg::FRAC,
   parameter int ACC_W   = 36,
   parameter bit RELU    = 1'b1
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] map_in,
   input  logic                     w_wr,
   input  logic [TAP_W-1:0]         w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   input  logic signed [DATA_W-1:0] bias,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] map_out,
   output logic                     done
);

   localparam int TAPS = K * K;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
   localparam int CNT_W = $clog2(NUM_OUT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OUT - 1);

   logic signed [DATA_W-1:0]   w_q [TAPS];
   logic signed [DATA_W-1:0]   w_d [TAPS];

   logic [TAP_W-1:0]           tap_q, tap_d;
   logic                       s1_valid_q, s1_valid_d;
   logic [TAP_W-1:0]           s1_tap_q, s1_tap_d;
   logic signed [DATA_W-1:0]   s1_pix_q, s1_pix_d;
   logic signed [DATA_W-1:0]   s1_w_q, s1_w_d;
   logic signed [DATA_W-1:0]   s1_bias_q, s1_bias_d;
   logic                       s2_valid_q, s2_valid_d;
   logic [TAP_W-1:0]           s2_tap_q, s2_tap_d;
   logic signed [2*DATA_W-1:0] s2_prod_q, s2_prod_d;
   logic signed [DATA_W-1:0]   s2_bias_q, s2_bias_d;
   logic                       s3_valid_q, s3_valid_d;
   logic [TAP_W-1:0]           s3_tap_q, s3_tap_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [DATA_W-1:0]   s3_bias_q, s3_bias_d;
   logic                       out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0]   map_out_q, map_out_d;
   logic                       done_q, done_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic                       fire;
   logic signed [DATA_W-1:0]   sat_result;

   // Weights are configuration state: never reset, writable even during reset.
   always_comb begin
      w_d = w_q;
      if (w_wr && (w_addr <= LAST_TAP)) begin
         w_d[w_addr] = w_data;
      end
   end

   always_ff @(posedge clk_in) begin
      w_q <= w_d;
   end

   m_conv_sat_relu #(
      .ACC_W (ACC_W),
      .FRAC  (FRAC),
      .RELU  (RELU)
   ) u_sat_relu (
      .acc    (acc_q),
      .bias   (s3_bias_q),
      .result (sat_result)
   );

   always_comb begin
      tap_d = tap_q;
      if (in_valid) begin
         tap_d = (tap_q == LAST_TAP) ? '0 : tap_q + 1'b1;
      end

      s1_valid_d = in_valid;
      s1_tap_d   = tap_q;
      s1_pix_d   = map_in;
      s1_w_d     = w_q[tap_q];
      s1_bias_d  = bias;

      s2_valid_d = s1_valid_q;
      s2_tap_d   = s1_tap_q;
      s2_prod_d  = s1_pix_q * s1_w_q;
      s2_bias_d  = s1_bias_q;

      // Tap 0 restarts the sum, so a following window never needs a clear cycle.
      s3_valid_d = s2_valid_q;
      s3_tap_d   = s2_tap_q;
      s3_bias_d  = s2_bias_q;
      acc_d      = acc_q;
      if (s2_valid_q) begin
         if (s2_tap_q == '0) begin
            acc_d = ACC_W'(s2_prod_q);
         end else begin
            acc_d = acc_q + ACC_W'(s2_prod_q);
         end
      end

      fire        = s3_valid_q && (s3_tap_q == LAST_TAP);
      out_valid_d = fire;
      map_out_d   = fire ? sat_result : map_out_q;
      done_d      = 1'b0;
      cnt_d       = cnt_q;
      if (fire) begin
         if (cnt_q == LAST_CNT) begin
            done_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         tap_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_tap_q    <= '0;
         s1_pix_q    <= '0;
         s1_w_q      <= '0;
         s1_bias_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_tap_q    <= '0;
         s2_prod_q   <= '0;
         s2_bias_q   <= '0;
         s3_valid_q  <= 1'b0;
         s3_tap_q    <= '0;
         s3_bias_q   <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         map_out_q   <= '0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         tap_q       <= tap_d;
         s1_valid_q  <= s1_valid_d;
         s1_tap_q    <= s1_tap_d;
         s1_pix_q    <= s1_pix_d;
         s1_w_q      <= s1_w_d;
         s1_bias_q   <= s1_bias_d;
         s2_valid_q  <= s2_valid_d;
         s2_tap_q    <= s2_tap_d;
         s2_prod_q   <= s2_prod_d;
         s2_bias_q   <= s2_bias_d;
         s3_valid_q  <= s3_valid_d;
         s3_tap_q    <= s3_tap_d;
         s3_bias_q   <= s3_bias_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         map_out_q   <= map_out_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign map_out   = map_out_q;
   assign done      = done_q;

endmodule

// File: tb/tb_m_conv_mac_3.sv
// Self-checking bench for m_conv_mac_3: a window-level reference model predicts
// every result; one RELU=1 and one RELU=0 instance share the same stimulus.
module tb_m_conv_mac_3;

   localparam int TAPS    = 9;
   localparam int NUM_OUT = 36;

   logic              clk      = 1'b0;
   logic              rst      = 1'b1;
   logic              in_valid = 1'b0;
   logic              w_wr     = 1'b0;
   logic [3:0]        w_addr   = '0;
   logic signed [15:0] map_in  = '0;
   logic signed [15:0] w_data  = '0;
   logic signed [15:0] bias    = '0;

   logic              ov_r, ov_n, done_r, done_n;
   logic signed [15:0] out_r, out_n;

   m_conv_mac_3 #(.RELU(1'b1)) dut_relu (
      .clk_in (clk), .rst_n (rst), .in_valid (in_valid), .map_in (map_in),
      .w_wr (w_wr), .w_addr (w_addr), .w_data (w_data), .bias (bias),
      .out_valid (ov_r), .map_out (out_r), .done (done_r)
   );

   m_conv_mac_3 #(.RELU(1'b0)) dut_norelu (
      .clk_in (clk), .rst_n (rst), .in_valid (in_valid), .map_in (map_in),
      .w_wr (w_wr), .w_addr (w_addr), .w_data (w_data), .bias (bias),
      .out_valid (ov_n), .map_out (out_n), .done (done_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     r;
      bit     done;
      longint cyc;
   } exp_t;

   exp_t   exp_q[$];
   longint m_w [TAPS];
   longint win_sum     = 0;
   int     win_idx     = 0;
   int     m_cnt       = 0;
   longint cyc         = 0;
   int     checks      = 0;
   int     failures    = 0;
   int     ov_total    = 0;
   int     done_total  = 0;
   int     last_done_at = 0;
   int     last_out_r  = 0;
   int     last_out_n  = 0;
   int     last_model  = 0;
   int     ov0, d0;

   // Q8.8 window result before ReLU: floor((sum + bias*2^8) / 2^8), clamped to 16 bits.
   function automatic int modelRaw(longint s, longint b);
      longint t;
      t = (s + b * 256) >>> 8;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      return int'(t);
   endfunction

   task automatic checkOutput(string name, logic signed [63:0] got, logic signed [63:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic applyStimulus(logic signed [15:0] pix, logic signed [15:0] b, int gap);
      @(negedge clk);
      in_valid = 1'b1;
      map_in   = pix;
      bias     = b;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic endStimulus();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic writeWeight(int a, logic signed [15:0] v);
      @(negedge clk);
      w_wr   = 1'b1;
      w_addr = 4'(a);
      w_data = v;
      @(negedge clk);
      w_wr = 1'b0;
   endtask

   task automatic writeAll(logic signed [15:0] v);
      for (int i = 0; i < TAPS; i++) writeWeight(i, v);
   endtask

   task automatic sendWindow(logic signed [15:0] pix, logic signed [15:0] b);
      for (int i = 0; i < TAPS; i++) applyStimulus(pix, b, 0);
   endtask

   task automatic drain(string name);
      endStimulus();
      repeat (8) @(negedge clk);
      checkOutput(name, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      fork
         // Reference model: tracks windows, weights and the output count at each edge.
         forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
               exp_q.delete();
               win_sum = 0;
               win_idx = 0;
               m_cnt   = 0;
            end else if (in_valid) begin
               win_sum += longint'(map_in) * m_w[win_idx];
               if (win_idx == TAPS - 1) begin
                  int r;
                  bit d;
                  r = modelRaw(win_sum, longint'(bias));
                  m_cnt++;
                  d = (m_cnt == NUM_OUT);
                  if (d) m_cnt = 0;
                  exp_q.push_back('{r, d, cyc});
                  last_model = r;
                  win_sum = 0;
                  win_idx = 0;
               end else begin
                  win_idx++;
               end
            end
            if (w_wr && w_addr < TAPS) m_w[w_addr] = longint'(w_data);
         end
         // Compare every result strobe against the model's prediction.
         forever begin
            @(negedge clk);
            if (ov_r || ov_n) begin
               ov_total++;
               if (done_r) begin
                  done_total++;
                  last_done_at = ov_total;
               end
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_out_valid got=1 expected=0");
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  checkOutput("out_valid_relu", ov_r, 1);
                  checkOutput("out_valid_norelu", ov_n, 1);
                  checkOutput("map_out_relu", out_r, (e.r < 0) ? 0 : e.r);
                  checkOutput("map_out_norelu", out_n, e.r);
                  checkOutput("done_relu", done_r, e.done);
                  checkOutput("done_norelu", done_n, e.done);
                  checkOutput("latency", cyc - e.cyc, 3);
               end
               last_out_r = int'(out_r);
               last_out_n = int'(out_n);
            end else if (done_r || done_n) begin
               checks++;
               failures++;
               $display("[TB] FAIL done_without_valid got=1 expected=0");
            end
         end
      join_none

      for (int i = 0; i < TAPS; i++) m_w[i] = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", ov_r, 0);
      checkOutput("reset_done", done_r, 0);
      checkOutput("reset_map_out", out_r, 0);
      checkOutput("reset_map_out_norelu", out_n, 0);
      rst = 1'b0;

      writeAll(16'sd256);
      sendWindow(16'sd256, 16'sd0);
      drain("drain_unity");
      checkOutput("unity_dut", last_out_r, 2304);
      checkOutput("unity_model", last_model, 2304);

      writeWeight(15, 16'sh1234);
      writeAll(16'sd32767);
      sendWindow(16'sd32767, 16'sd32767);
      drain("drain_sat");
      checkOutput("sat_relu", last_out_r, 32767);
      checkOutput("sat_norelu", last_out_n, 32767);

      writeAll(-16'sd256);
      sendWindow(16'sd512, 16'sd0);
      drain("drain_neg");
      checkOutput("neg_relu", last_out_r, 0);
      checkOutput("neg_norelu", last_out_n, -4608);
      checkOutput("neg_model", last_model, -4608);

      writeAll(16'sd256);
      for (int k = 1; k <= TAPS; k++) applyStimulus(16'(256 * k), 16'sd0, (k % 3) + 1);
      drain("drain_gaps");
      checkOutput("gaps_dut", last_out_r, 11520);
      checkOutput("gaps_model", last_model, 11520);

      for (int k = 0; k < 5; k++) applyStimulus(16'sd256, 16'sd0, 0);
      endStimulus();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("partial_no_output", exp_q.size(), 0);
      sendWindow(16'sd256, 16'sd0);
      drain("drain_after_reset");
      checkOutput("after_reset_dut", last_out_r, 2304);

      rst = 1'b1;
      writeWeight(0, 16'sd512);
      rst = 1'b0;
      ov0 = ov_total;
      d0  = done_total;
      for (int j = 1; j <= NUM_OUT; j++) sendWindow(16'(j), 16'sd0);
      drain("drain_stream");
      checkOutput("stream_valid_count", ov_total - ov0, NUM_OUT);
      checkOutput("stream_done_count", done_total - d0, 1);
      checkOutput("stream_done_index", last_done_at - ov0, NUM_OUT);
      checkOutput("stream_last_value", last_out_r, 360);
      sendWindow(16'sd37, 16'sd0);
      drain("drain_wrap");
      checkOutput("wrap_no_done", done_total - d0, 1);
      checkOutput("wrap_value", last_out_r, 370);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
